pc_unit: RTL

Parametrised program-counter unit for the word-addressed MIPS core, a successor to the single-width PC register. It selects the next PC from sequential increment, PC-relative branch, absolute jump, jump-and-link, and return. It adds a stall hold, a configurable reset vector, a registered link value, and an optional return-address stack (RAS) with overflow/underflow flags. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select (seq/branch/jump/jal/ret), stall, link register.
// Optional return-address stack enabled by defining PC_UNIT_RAS_EN.
module pc_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      RAS_DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [WIDTH-1:0]             ain,
   input  logic                         pcsel,
   input  logic                         jump,
   input  logic                         jal,
   input  logic                         ret,
   input  logic [WIDTH-1:0]             rs_val,
   output logic [WIDTH-1:0]             aout,
   output logic [WIDTH-1:0]             link,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] link_q, link_d;
   logic [WIDTH-1:0] pc_inc;

   assign pc_inc = pc_q + WIDTH'(1);

`ifdef PC_UNIT_RAS_EN
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PtrW-1:0]  top_q, top_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push;

   always_comb begin
      pc_d   = pc_q;
      link_d = link_q;
      top_d  = top_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      push   = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (cnt_q != '0) begin
               pc_d  = ras_mem[top_q];
               top_d = top_q - PtrW'(1);
               cnt_d = cnt_q - CntW'(1);
            end else begin
               pc_d  = rs_val;
               unf_d = 1'b1;
            end
         end else if (jal) begin
            pc_d   = ain;
            link_d = pc_inc;
            push   = 1'b1;
            // When full, slot top+1 holds the oldest entry, so advancing overwrites it.
            top_d  = top_q + PtrW'(1);
            if (cnt_q == CntW'(RAS_DEPTH)) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end else if (jump) begin
            pc_d = ain;
         end else if (pcsel) begin
            pc_d = pc_inc + ain;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entry contents are never reset; the count alone defines validity.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         ras_mem[top_d] <= pc_inc;
      end
   end

   assign ras_count = cnt_q;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;
`else
   always_comb begin
      pc_d   = pc_q;
      link_d = link_q;
      if (!stall) begin
         if (ret) begin
            pc_d = rs_val;
         end else if (jal) begin
            pc_d   = ain;
            link_d = pc_inc;
         end else if (jump) begin
            pc_d = ain;
         end else if (pcsel) begin
            pc_d = pc_inc + ain;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   assign ras_count = '0;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_VECTOR;
         link_q <= '0;
      end else begin
         pc_q   <= pc_d;
         link_q <= link_d;
      end
   end

   assign aout = pc_q;
   assign link = link_q;

endmodule
